// File: rtl/cbc_chain_engine.sv
// CBC chaining engine: wraps an external iterative block-cipher core with CBC encrypt/decrypt chaining.
// Optional CBC-MAC tag output is enabled by defining CBC_MAC_EN.

module cbc_chain_engine_chk #(
  parameter int BLOCK_W = 128
) (
  input logic               clk,
  input logic               rst_n,
  input logic               in_ready,
  input logic               busy,
  input logic               core_req,
  input logic               core_ack,
  input logic [BLOCK_W-1:0] core_din,
  input logic               out_valid,
  input logic               out_ready,
  input logic [BLOCK_W-1:0] out_data,
  input logic               out_last
);

  // a request stays up with stable data until the core answers
  a_core_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (core_req && !core_ack) |=> (core_req && $stable(core_din)));

  // a stalled output is held unchanged
  a_out_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

  // only one block in flight
  a_no_accept_busy: assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> !in_ready);

endmodule

module cbc_chain_engine #(
  parameter int BLOCK_W = 128,
  parameter int KEY_W   = 128,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               iv_load,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_last,
  output logic               core_req,
  output logic               core_dec,
  output logic [BLOCK_W-1:0] core_din,
  output logic [KEY_W-1:0]   core_key,
  input  logic               core_ack,
  input  logic [BLOCK_W-1:0] core_dout,
  output logic [CNT_W-1:0]   blk_cnt,
  output logic               busy
`ifdef CBC_MAC_EN
  ,
  output logic [BLOCK_W-1:0] mac_tag,
  output logic               mac_valid
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t             state_r;
  logic [BLOCK_W-1:0] iv_r;
  logic [BLOCK_W-1:0] chain_r;
  logic [BLOCK_W-1:0] hold_r;
  logic [BLOCK_W-1:0] core_din_r;
  logic [BLOCK_W-1:0] out_data_r;
  logic               last_r;
  logic               mode_r;
  logic               core_req_r;
  logic               out_valid_r;
  logic               out_last_r;
  logic [CNT_W-1:0]   blk_cnt_r;
  logic               dec_sel_s;
  logic [CNT_W-1:0]   blk_cnt_inc_s;
`ifdef CBC_MAC_EN
  logic [BLOCK_W-1:0] mac_tag_r;
  logic               mac_valid_r;
`endif

  // direction of the block being accepted: only the first block of a message samples mode
  always_comb begin
    dec_sel_s = mode_r;
    if (blk_cnt_r == {CNT_W{1'b0}}) begin
      dec_sel_s = mode;
    end else begin
      dec_sel_s = mode_r;
    end
  end

  // saturating completed-block count
  always_comb begin
    blk_cnt_inc_s = blk_cnt_r;
    if (blk_cnt_r != {CNT_W{1'b1}}) begin
      blk_cnt_inc_s = blk_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      blk_cnt_inc_s = blk_cnt_r;
    end
  end

  // chaining FSM: accept one block, run the core, present the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      iv_r        <= {BLOCK_W{1'b0}};
      chain_r     <= {BLOCK_W{1'b0}};
      hold_r      <= {BLOCK_W{1'b0}};
      core_din_r  <= {BLOCK_W{1'b0}};
      out_data_r  <= {BLOCK_W{1'b0}};
      last_r      <= 1'b0;
      mode_r      <= 1'b0;
      core_req_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      blk_cnt_r   <= {CNT_W{1'b0}};
`ifdef CBC_MAC_EN
      mac_tag_r   <= {BLOCK_W{1'b0}};
      mac_valid_r <= 1'b0;
`endif
    end else begin
`ifdef CBC_MAC_EN
      mac_valid_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (iv_load) begin
            iv_r      <= iv;
            chain_r   <= iv;
            blk_cnt_r <= {CNT_W{1'b0}};
          end else if (in_valid) begin
            hold_r     <= in_data;
            last_r     <= in_last;
            mode_r     <= dec_sel_s;
            core_din_r <= dec_sel_s ? in_data : (in_data ^ chain_r);
            core_req_r <= 1'b1;
            state_r    <= ST_CORE;
          end
        end
        ST_CORE: begin
          if (core_ack) begin
            core_req_r  <= 1'b0;
            out_valid_r <= 1'b1;
            out_last_r  <= last_r;
            if (mode_r) begin
              out_data_r <= core_dout ^ chain_r;
              chain_r    <= hold_r;
            end else begin
              out_data_r <= core_dout;
              chain_r    <= core_dout;
            end
            state_r <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            state_r     <= ST_IDLE;
            // end of message: rewind the chain to the IV for the next one
            if (last_r) begin
              chain_r   <= iv_r;
              blk_cnt_r <= {CNT_W{1'b0}};
            end else begin
              blk_cnt_r <= blk_cnt_inc_s;
            end
`ifdef CBC_MAC_EN
            if (last_r && !mode_r) begin
              mac_tag_r   <= out_data_r;
              mac_valid_r <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          core_req_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE) & ~iv_load;
  assign busy      = (state_r != ST_IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign core_req  = core_req_r;
  assign core_dec  = mode_r;
  assign core_din  = core_din_r;
  assign core_key  = key;
  assign blk_cnt   = blk_cnt_r;
`ifdef CBC_MAC_EN
  assign mac_tag   = mac_tag_r;
  assign mac_valid = mac_valid_r;
`endif

  cbc_chain_engine_chk #(.BLOCK_W(BLOCK_W)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ready  (in_ready),
    .busy      (busy),
    .core_req  (core_req),
    .core_ack  (core_ack),
    .core_din  (core_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule
